// File: rtl/multiply_accum_tree_stream.sv
// rtl/multiply_accum_tree_stream.sv - pipelined dot-product engine with TREE_BASE-ary adder tree and group accumulation
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_val / in_rdy               input beat handshake
//   row, col                      packed operand vectors, element e at [(e+1)*DATA_WIDTH-1 : e*DATA_WIDTH]
//   is_signed                     per-beat two's-complement mode
//   first / last                  group delimiters
//   addr_i_in / addr_k_in         address sideband, reported from the last beat of a group
//   out_val / out_rdy             result handshake
//   sum_out                       accumulated group result
//   addr_i_out / addr_k_out       address sideband of the result
//
// DATA_LENGTH must be >= 2, and ACC_WIDTH >= 2*DATA_WIDTH + LEVELS*ceil(log2(TREE_BASE)).
module multiply_accum_tree_stream #(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_LENGTH     = 64,
    parameter int TREE_BASE       = 2,
    parameter int ACC_WIDTH       = 32,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_val,
    output logic                              in_rdy,
    input  logic [DATA_WIDTH*DATA_LENGTH-1:0] row,
    input  logic [DATA_WIDTH*DATA_LENGTH-1:0] col,
    input  logic                              is_signed,
    input  logic                              first,
    input  logic                              last,
    input  logic [ADDRESS_WIDTH_I-1:0]        addr_i_in,
    input  logic [ADDRESS_WIDTH_K-1:0]        addr_k_in,
    output logic                              out_val,
    input  logic                              out_rdy,
    output logic [ACC_WIDTH-1:0]              sum_out,
    output logic [ADDRESS_WIDTH_I-1:0]        addr_i_out,
    output logic [ADDRESS_WIDTH_K-1:0]        addr_k_out
);

    function automatic int calc_levels(input int n, input int b);
        int p;
        int l;
        p = 1;
        l = 0;
        while (p < n) begin
            p = p * b;
            l = l + 1;
        end
        return l;
    endfunction

    function automatic int ipow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    localparam int LEVELS = calc_levels(DATA_LENGTH, TREE_BASE);
    localparam int LEAVES = ipow(TREE_BASE, LEVELS);
    localparam int LB     = $clog2(TREE_BASE);
    localparam int PW     = 2 * DATA_WIDTH;
    // Every tree node is carried at the root width; leaves are extended once
    // after the multiply so the adds below are exact in both modes.
    localparam int TW     = PW + LEVELS * LB;
    localparam int LAST   = LEVELS + 1;   // stage index holding the root sum

    function automatic int lvl_nodes(input int l);
        return LEAVES / ipow(TREE_BASE, l);
    endfunction

    // Tree levels 1..LEVELS are packed back to back into one array.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int j = 1; j < l; j++) o = o + lvl_nodes(j);
        return o;
    endfunction

    localparam int TOTAL = lvl_off(LEVELS + 1);
    localparam int ROOT  = lvl_off(LEVELS);

    logic en;
    assign en     = out_rdy | ~out_val;
    assign in_rdy = en;

    // Per-stage control: index 0 = input register, 1 = multiply, 1+l = tree level l.
    logic [LAST:0]              st_val;
    logic [LAST:0]              st_sg;
    logic [LAST:0]              st_fs;
    logic [LAST:0]              st_ls;
    logic [ADDRESS_WIDTH_I-1:0] st_ai [LAST+1];
    logic [ADDRESS_WIDTH_K-1:0] st_ak [LAST+1];

    logic [DATA_WIDTH*DATA_LENGTH-1:0] row_q;
    logic [DATA_WIDTH*DATA_LENGTH-1:0] col_q;
    logic [TW-1:0] prod    [DATA_LENGTH];
    logic [TW-1:0] prod_d  [DATA_LENGTH];
    logic [TW-1:0] tnode   [TOTAL];
    logic [TW-1:0] tnode_d [TOTAL];

    logic [TW-1:0]              tsum;
    logic [ACC_WIDTH-1:0]       tree_ext;
    logic [ACC_WIDTH-1:0]       acc;
    logic                       sa_res;   // SA holds a valid last beat
    logic [ADDRESS_WIDTH_I-1:0] sa_ai;
    logic [ADDRESS_WIDTH_K-1:0] sa_ak;

    // Operands are extended to the product width so the low PW bits of the
    // product are correct for both signed and unsigned beats.
    always_comb begin
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [PW-1:0]         ax;
        logic [PW-1:0]         bx;
        logic [PW-1:0]         pr;
        for (int e = 0; e < DATA_LENGTH; e++) begin
            a  = row_q[e*DATA_WIDTH +: DATA_WIDTH];
            b  = col_q[e*DATA_WIDTH +: DATA_WIDTH];
            ax = {{DATA_WIDTH{st_sg[0] & a[DATA_WIDTH-1]}}, a};
            bx = {{DATA_WIDTH{st_sg[0] & b[DATA_WIDTH-1]}}, b};
            pr = ax * bx;
            prod_d[e] = {{(TW-PW){st_sg[0] & pr[PW-1]}}, pr};
        end
    end

    // Level 1 reads the products; leaf slots beyond DATA_LENGTH contribute 0.
    always_comb begin
        logic [TW-1:0] s;
        int            c;
        tnode_d = tnode;
        for (int l = 1; l <= LEVELS; l++) begin
            for (int n = 0; n < lvl_nodes(l); n++) begin
                s = '0;
                for (int b = 0; b < TREE_BASE; b++) begin
                    c = n * TREE_BASE + b;
                    if (l == 1) begin
                        if (c < DATA_LENGTH) s = s + prod[c];
                    end else begin
                        s = s + tnode[lvl_off(l-1) + c];
                    end
                end
                tnode_d[lvl_off(l) + n] = s;
            end
        end
    end

    assign tsum = tnode[ROOT];

    generate
        if (ACC_WIDTH > TW) begin : g_ext
            assign tree_ext = {{(ACC_WIDTH-TW){st_sg[LAST] & tsum[TW-1]}}, tsum};
        end else begin : g_noext
            assign tree_ext = tsum;
        end
    endgenerate

    // Datapath registers carry no reset: nothing consumes them without a valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            row_q <= row;
            col_q <= col;
            prod  <= prod_d;
            tnode <= tnode_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_val <= '0;
            st_sg  <= '0;
            st_fs  <= '0;
            st_ls  <= '0;
            for (int s = 0; s <= LAST; s++) begin
                st_ai[s] <= '0;
                st_ak[s] <= '0;
            end
            acc        <= '0;
            sa_res     <= 1'b0;
            sa_ai      <= '0;
            sa_ak      <= '0;
            out_val    <= 1'b0;
            sum_out    <= '0;
            addr_i_out <= '0;
            addr_k_out <= '0;
        end else if (en) begin
            st_val <= {st_val[LAST-1:0], in_val};
            st_sg  <= {st_sg[LAST-1:0], is_signed};
            st_fs  <= {st_fs[LAST-1:0], first};
            st_ls  <= {st_ls[LAST-1:0], last};
            st_ai[0] <= addr_i_in;
            st_ak[0] <= addr_k_in;
            for (int s = 1; s <= LAST; s++) begin
                st_ai[s] <= st_ai[s-1];
                st_ak[s] <= st_ak[s-1];
            end

            if (st_val[LAST]) begin
                acc <= st_fs[LAST] ? tree_ext : acc + tree_ext;
            end
            sa_res <= st_val[LAST] & st_ls[LAST];
            sa_ai  <= st_ai[LAST];
            sa_ak  <= st_ak[LAST];

            // en=1 means the previous result was taken or never existed,
            // so out_val simply follows whether a new result arrives.
            out_val <= sa_res;
            if (sa_res) begin
                sum_out    <= acc;
                addr_i_out <= sa_ai;
                addr_k_out <= sa_ak;
            end
        end
    end

endmodule
